// File: rtl/queue4_arb.sv
// Round-robin write arbiter and occupancy tracker for the shared 4-bit x 64 queue.
// Optional almost-full deferral of newly rising requests is enabled by defining QARB_AFULL_EN.
module queue4_arb #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 64,
    parameter int CW    = 7
`ifdef QARB_AFULL_EN
    , parameter int AFULL_LEVEL = 56
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    input  logic              pop,
    input  logic              flush,
    output logic [3:0]        q_din,
    output logic              q_wr_en,
    output logic              q_rd_en,
    output logic              q_rst,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
`ifdef QARB_AFULL_EN
    , output logic            afull
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [NREQ-1:0]   elig;
    logic [2*NREQ-1:0] elig_dbl, elig_rot;
    logic [NREQ-1:0]   gnt_c;
    logic [3:0]        din_c;
    logic              found;
    int                off;
    int                gidx;
    int                gnext;
    logic              clr;
    logic              gnt_en;
    logic              wr;
    logic              rd;

    assign clr    = rst | flush;
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign gnt_en = ~full & ~clr;

`ifdef QARB_AFULL_EN
    logic              afull_q, afull_d;
    logic [NREQ-1:0]   req_prev_q, mask_q, mask_d, rise, hold;

    // A request that rises while afull is high stays masked until afull drops or it is withdrawn.
    assign rise    = req & ~req_prev_q;
    assign hold    = afull_q ? (mask_q | rise) : '0;
    assign mask_d  = hold & req;
    assign elig    = req & ~hold;
    assign afull_d = (count_d >= CW'(AFULL_LEVEL));
    assign afull   = afull_q;
`else
    assign elig    = req;
`endif

    // Rotate eligibility so that bit 0 is the current priority holder.
    assign elig_dbl = {elig, elig};
    assign elig_rot = elig_dbl >> ptr_q;

    always_comb begin
        found = 1'b0;
        off   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig_rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        gidx  = int'(ptr_q) + off;
        if (gidx >= NREQ) gidx = gidx - NREQ;
        gnext = (gidx + 1 >= NREQ) ? 0 : gidx + 1;
        gnt_c = '0;
        din_c = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (found && gnt_en && gidx == j) begin
                gnt_c[j] = 1'b1;
                din_c    = req_data[4*j +: 4];
            end
        end
    end

    assign wr      = found & gnt_en;
    assign rd      = pop & ~empty & ~clr;
    assign gnt     = gnt_c;
    assign q_din   = din_c;
    assign q_wr_en = wr;
    assign q_rd_en = rd;
    assign q_rst   = clr;
    assign count   = count_q;

    always_comb begin
        ptr_d   = wr ? PW'(gnext) : ptr_q;
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (wr && !rd)
            count_d = count_q + CW'(1);
        else if (rd && !wr)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

`ifdef QARB_AFULL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            afull_q    <= 1'b0;
            mask_q     <= '0;
            req_prev_q <= '0;
        end else begin
            afull_q    <= afull_d;
            mask_q     <= mask_d;
            req_prev_q <= req;
        end
    end
`endif

endmodule

// File: tb/tb_queue4_arb.sv
// Directed bench for queue4_arb: arbitration order, fill/drain, full/empty corner cases, flush, reset.
// The almost-full scenario runs only when QARB_AFULL_EN is defined.
module tb_queue4_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic        pop;
    logic        flush;
    logic [3:0]  q_din;
    logic        q_wr_en;
    logic        q_rd_en;
    logic        q_rst;
    logic [6:0]  count;
    logic        full;
    logic        empty;
`ifdef QARB_AFULL_EN
    logic        afull;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    queue4_arb dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .pop      (pop),
        .flush    (flush),
        .q_din    (q_din),
        .q_wr_en  (q_wr_en),
        .q_rd_en  (q_rd_en),
        .q_rst    (q_rst),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef QARB_AFULL_EN
        , .afull  (afull)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Settle inputs applied just after an edge, then sample before the next edge.
    task automatic settle();
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b1111;
        req_data = 16'h4A21;   // producer0=1, producer1=2, producer2=A, producer3=4
        pop      = 1'b1;
        flush    = 1'b0;

        repeat (3) next_cycle();
        settle();
        chk("rst_gnt",   gnt, 4'b0000);
        chk("rst_wr",    q_wr_en, 1'b0);
        chk("rst_rd",    q_rd_en, 1'b0);
        chk("rst_qrst",  q_rst, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full",  full, 1'b0);

        // Round-robin with all four requesting.
        next_cycle();
        rst = 1'b0;
        pop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("rr_gnt",   gnt, 4'b0001 << (k % 4));
            chk("rr_count", count, k);
            chk("rr_din",   q_din, (k % 4) + 1 == 3 ? 4'hA : 4'((k % 4) + 1));
            next_cycle();
        end
        req = 4'b0000;
        settle();
        chk("rr_count5", count, 5);
        chk("idle_gnt",  gnt, 4'b0000);
        chk("idle_wr",   q_wr_en, 1'b0);
        next_cycle();

        // Drain five, then a pop while empty is ignored.
        pop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("drain_rd",    q_rd_en, 1'b1);
            chk("drain_count", count, 5 - k);
            next_cycle();
        end
        settle();
        chk("empty_pop_rd", q_rd_en, 1'b0);
        chk("empty_flag",   empty, 1'b1);
        next_cycle();
        pop = 1'b0;
        settle();
        chk("empty_pop_cnt", count, 0);
        next_cycle();

        // Fill from producer 2 for 70 cycles.
        req = 4'b0100;
        for (int i = 0; i < 70; i++) begin
            settle();
            chk("fill_gnt",   gnt, i < 64 ? 4'b0100 : 4'b0000);
            chk("fill_count", count, i < 64 ? i : 64);
            if (i < 64) chk("fill_din", q_din, 4'hA);
            if (i == 63) chk("fill_notfull", full, 1'b0);
            if (i == 64) chk("fill_full", full, 1'b1);
            next_cycle();
        end

        // Full with simultaneous pop and request.
        pop = 1'b1;
        settle();
        chk("fullpop_gnt", gnt, 4'b0000);
        chk("fullpop_rd",  q_rd_en, 1'b1);
        next_cycle();
        pop = 1'b0;
        settle();
        chk("fullpop_cnt63", count, 63);
        chk("fullpop_nf",    full, 1'b0);
        chk("fullpop_gnt2",  gnt, 4'b0100);
        next_cycle();
        req = 4'b0000;
        settle();
        chk("refull_cnt",  count, 64);
        chk("refull_full", full, 1'b1);
        next_cycle();

        // Pop all 64 entries.
        pop = 1'b1;
        for (int k = 0; k < 64; k++) begin
            settle();
            chk("pop64_rd",  q_rd_en, 1'b1);
            chk("pop64_cnt", count, 64 - k);
            next_cycle();
        end
        pop = 1'b0;
        settle();
        chk("pop64_empty", empty, 1'b1);
        chk("pop64_cnt0",  count, 0);
        next_cycle();

        // Empty with simultaneous pop and request (ptr is 3, so producer 1 wins after wrap).
        req = 4'b0010;
        pop = 1'b1;
        settle();
        chk("emptywr_rd",  q_rd_en, 1'b0);
        chk("emptywr_gnt", gnt, 4'b0010);
        chk("emptywr_din", q_din, 4'h2);
        next_cycle();
        req = 4'b0000;
        settle();
        chk("emptywr_cnt", count, 1);
        chk("emptywr_rd2", q_rd_en, 1'b1);
        next_cycle();
        pop = 1'b0;
        settle();
        chk("emptywr_cnt0", count, 0);
        next_cycle();

        // Build count to 10 from producer 0, leaving ptr at 1.
        req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk("pre_flush_gnt", gnt, 4'b0001);
            next_cycle();
        end
        req   = 4'b0010;
        flush = 1'b1;
        pop   = 1'b1;
        settle();
        chk("flush_cnt10", count, 10);
        chk("flush_gnt",   gnt, 4'b0000);
        chk("flush_wr",    q_wr_en, 1'b0);
        chk("flush_rd",    q_rd_en, 1'b0);
        chk("flush_qrst",  q_rst, 1'b1);
        next_cycle();
        flush = 1'b0;
        pop   = 1'b0;
        req   = 4'b1111;
        settle();
        chk("postflush_cnt",   count, 0);
        chk("postflush_empty", empty, 1'b1);
        chk("postflush_gnt",   gnt, 4'b0010);
        next_cycle();
        settle();
        chk("postflush_gnt2", gnt, 4'b0100);
        chk("postflush_cnt1", count, 1);
        next_cycle();

        // Reset mid-burst.
        rst = 1'b1;
        pop = 1'b1;
        settle();
        chk("midrst_gnt", gnt, 4'b0000);
        chk("midrst_wr",  q_wr_en, 1'b0);
        chk("midrst_rd",  q_rd_en, 1'b0);
        next_cycle();
        rst = 1'b0;
        pop = 1'b0;
        settle();
        chk("midrst_cnt",   count, 0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_full",  full, 1'b0);
        chk("midrst_ptr0",  gnt, 4'b0001);
        next_cycle();
        req = 4'b0000;
        settle();
        chk("midrst_cnt1", count, 1);
        next_cycle();

`ifdef QARB_AFULL_EN
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        req = 4'b0001;
        for (int k = 0; k < 56; k++) begin
            settle();
            chk("af_ramp_gnt", gnt, 4'b0001);
            chk("af_ramp_cnt", count, k);
            chk("af_ramp_af",  afull, 1'b0);
            next_cycle();
        end
        req = 4'b1001;
        settle();
        chk("af_cnt56", count, 56);
        chk("af_high",  afull, 1'b1);
        chk("af_defer", gnt, 4'b0001);
        next_cycle();
        settle();
        chk("af_defer2", gnt, 4'b0001);
        chk("af_cnt57",  count, 57);
        next_cycle();
        req = 4'b1000;
        pop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("af_hold_gnt", gnt, 4'b0000);
            chk("af_pop_cnt",  count, 58 - k);
            next_cycle();
        end
        pop = 1'b0;
        settle();
        chk("af_cnt55",  count, 55);
        chk("af_low",    afull, 1'b0);
        chk("af_served", gnt, 4'b1000);
        chk("af_din",    q_din, 4'h4);
        next_cycle();
        req = 4'b0000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/queue4_arb.md
# queue4_arb

Round-robin write arbiter and occupancy controller for the shared 4-bit, 64-entry distributed-RAM queue. Up to NREQ producers compete for the queue's single write port. The block grants one producer per cycle, muxes its nibble onto the queue input and tracks occupancy. Because the queue itself reports no full condition, this block supplies the real full/empty/count and never writes a full queue or reads an empty one.

## Interface
- NREQ, 4: number of producers, 2..8.
- DEPTH, 64: queue capacity. Must equal the queue's 6-bit address space.
- CW, 7: occupancy counter width, sized for 0..DEPTH.
- AFULL_LEVEL, 56: almost-full threshold. Only used with QARB_AFULL_EN.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-producer write request; level, held until granted
- req_data  in  4*NREQ  producer nibbles; producer i uses bits [4i+3:4i]
- gnt  out  NREQ  one-hot grant; the nibble is written in the same cycle
- pop  in  1  consumer read request
- flush  in  1  synchronous queue clear
- q_din  out  4  to queue din
- q_wr_en  out  1  to queue wr_en
- q_rd_en  out  1  to queue rd_en
- q_rst  out  1  to queue rst; equals rst | flush
- count  out  CW  registered occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- afull  out  1  count >= AFULL_LEVEL (QARB_AFULL_EN only)

## Operation
- Priority pointer ptr, 0..NREQ-1, is registered. It names the producer with highest priority.
- Grant search starts at ptr and wraps modulo NREQ. The first asserted req wins.
- gnt is combinational from req, ptr and full. It is all-zero when full, when flush is high, or when no req is asserted.
- On a grant to producer i:
  - q_wr_en = 1
  - q_din = req_data[4i+3:4i]
  - ptr <= (i+1) mod NREQ on the next edge
- With no grant, ptr holds its value.
- q_rd_en = pop & ~empty & ~flush. A pop while empty is ignored and has no side effects.
- Count update on each edge:
  - write only: +1
  - read only: -1
  - write and read: unchanged
  - neither: unchanged
- Count never leaves 0..DEPTH.
- When full is high, no write is granted even if a pop occurs in the same cycle. The freed slot becomes grantable on the following cycle.
- When empty is high, a write and a pop in the same cycle produce a write only. The consumer must wait one cycle to read.
- flush clears count to 0 and holds q_rst high, which clears the queue pointers. ptr is preserved. Any write or read in the flush cycle is suppressed.
- Reset state: ptr = 0, count = 0. With rst high, gnt = 0, q_wr_en = 0 and q_rd_en = 0.

## Timing
- Grant-to-write latency is 0: the nibble enters the queue on the same clk edge on which gnt is high.
- count, full, empty and afull update one cycle after the write or read.
- Queue read data is valid on the queue dout in the cycle q_rd_en is asserted, because the queue's RAM read is asynchronous on ra. The consumer samples data in the same cycle as pop & ~empty.
- When rst or flush is asserted mid-burst, the cycle's write or read is dropped. The block presents full = 0 and empty = 1 in the next cycle.
- The combinational path is req → gnt → q_wr_en/q_din. Producers must present req from a register.

## Configuration
- QARB_AFULL_EN defined:
  - afull output exists, registered together with count.
  - Any producer whose req rises while afull is high is deferred. Requests already asserted before afull rose continue to be arbitrated.
  - Deferral is tracked by a per-producer registered mask, cleared when afull falls.
- QARB_AFULL_EN undefined: the afull port, the mask logic and AFULL_LEVEL are absent. Arbitration depends only on full.

## Test plan
- Reset with req = 4'b1111 held: after reset, gnt sequence is 0001, 0010, 0100, 1000, 0001. count reaches 5 after 5 cycles.
- Fill test: req[2] held with data 0xA for 70 cycles, no pop. Expect 64 grants, then count = 64, full = 1, gnt = 0 for the last 6 cycles. Popping 64 times returns 0xA, and empty = 1 after the last pop.
- Full with simultaneous pop and req: no grant that cycle and count goes to 63. Grant occurs the next cycle and count returns to 64.
- Empty with simultaneous pop and req: q_rd_en = 0, count = 1 next cycle. A pop then reads the written nibble.
- Flush at count = 10 with req[1] high: gnt = 0 that cycle. Next cycle count = 0, empty = 1, and ptr is unchanged, shown by the grant order resuming from it.
- QARB_AFULL_EN with AFULL_LEVEL = 56: at count = 56, afull = 1. A newly rising req[3] gets no grant while already-held req[0] continues to be granted. req[3] is served after pops drop count to 55.
